// File: rtl/dmem_arb_pkg.sv
// Shared defaults and types for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef logic port_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between the two dmem requesters.
// Fixed priority (port 0 first) by default; round-robin under DMEM_ARB_RR_EN.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic  req0_i,
    input  logic  req1_i,
`ifdef DMEM_ARB_RR_EN
    input  port_t last_i,
`endif
    output logic  any_o,
    output port_t win_o
);

    always_comb begin
        any_o = req0_i | req1_i;
`ifdef DMEM_ARB_RR_EN
        // Under contention the port that did not win last time goes next.
        if (req0_i && req1_i) begin
            win_o = ~last_i;
        end else begin
            win_o = req0_i ? 1'b0 : 1'b1;
        end
`else
        win_o = req0_i ? 1'b0 : 1'b1;
`endif
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two requesters onto the single-port dmem with req/gnt/rvalid.
// Define DMEM_ARB_RR_EN for round-robin arbitration instead of fixed priority.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(READ_LAT - 1);

    state_t            state_q, state_d;
    port_t             win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              any_req;
    port_t             pick;
`ifdef DMEM_ARB_RR_EN
    port_t             last_q, last_d;
`endif

    dmem_arb_pick u_pick (
        .req0_i (req0),
        .req1_i (req1),
`ifdef DMEM_ARB_RR_EN
        .last_i (last_q),
`endif
        .any_o  (any_req),
        .win_o  (pick)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                    win_d   = pick;
`ifdef DMEM_ARB_RR_EN
                    last_d  = pick;
`endif
                    if (pick == 1'b0) begin
                        we_d   = we0;
                        addr_d = addr0;
                        data_d = wdata0;
                    end else begin
                        we_d   = we1;
                        addr_d = addr1;
                        data_d = wdata1;
                    end
                end
            end
            ST_ISSUE: begin
                // Writes finish here; reads wait out the memory latency.
                if (we_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_INIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt0    = (state_q == ST_ISSUE) && (win_q == 1'b0);
        gnt1    = (state_q == ST_ISSUE) && (win_q == 1'b1);
        wren    = (state_q == ST_ISSUE) && we_q;
        rvalid0 = (state_q == ST_WAIT) && (cnt_q == '0) && (win_q == 1'b0);
        rvalid1 = (state_q == ST_WAIT) && (cnt_q == '0) && (win_q == 1'b1);
        busy    = (state_q != ST_IDLE);
    end

    assign address_dmem = addr_q;
    assign data         = data_q;
    assign rdata        = q_dmem;

endmodule
